iob_timer_alarm_ctrl: RTL and testbench
=======================================

// Module: iob_timer_alarm_ctrl
// PURPOSE
//  Multi-channel alarm scheduler for the 64-bit free-running timer counter (TIMER_VALUE).
//  Software programs N alarm channels, each with a 64-bit deadline and an optional period, over a native CPU slave port.
//  One shared 64-bit comparator is time-multiplexed over the channels by a round-robin scanner.
//  Matches set per-channel pending bits and drive a single level interrupt.
// PARAMETERS
//  N_ALARMS  4   number of alarm channels, 1..8
//  ADDR_W    5   word-address width; must satisfy 2^ADDR_W >= 4*N_ALARMS+2
//  DATA_W    32  CPU data width; fixed at 32
// PORTS
//  clk          in   1         system clock
//  rst          in   1         asynchronous reset, active-high
//  timer_value  in   64        current TIMER_VALUE from the timer core
//  valid        in   1         CPU request
//  address      in   ADDR_W    word address
//  wdata        in   DATA_W    write data
//  wstrb        in   DATA_W/8  byte strobes; |wstrb=write, else read; bytes written only where strobe set
//  rdata        out  DATA_W    read data, valid when ready=1
//  ready        out  1         request done; registered, asserted the cycle after valid
//  irq          out  1         |(pending & mask), registered
// BEHAVIOUR
//  Register map (word address):
//   - 4*ch+0 DEADLINE_LO; 4*ch+1 DEADLINE_HI; 4*ch+2 PERIOD (32b)
//   - 4*ch+3 CTRL: bit0 EN, bit1 PERIODIC
//   - 4*N PENDING (W1C, bits[N-1:0]); 4*N+1 MASK (RW)
//   - Unmapped addresses read 0; writes to them are ignored.
//  Reset: all deadline/period/ctrl/pending/mask = 0; scan pointer = 0; ready=0, rdata=0, irq=0.
//  Bus: ready=1 exactly one cycle after each valid cycle. rdata is registered and reflects register state as of the valid cycle.
//  Scanner: ptr advances 0..N-1 and wraps to 0 every cycle, unconditionally.
//   - Channel ptr matches when EN=1 and timer_value >= deadline (unsigned 64-bit).
//   - On a match, the same cycle's edge does:
//     - set pending[ptr];
//     - if PERIODIC=1 and PERIOD!=0: deadline <= deadline + PERIOD (mod 2^64), EN stays 1;
//     - otherwise EN <= 0 (one-shot; PERIOD=0 forces one-shot).
//  Latency: detection occurs at most N cycles after timer_value first reaches the deadline; irq rises 1 cycle after pending sets.
//  Catch-up: the reload adds to the old deadline, not to timer_value. A periodic channel that is behind fires on each of its scan slots until it catches up.
//  Deadline writes to a channel with EN=1 are ignored. Software must clear EN, write LO/HI, then set EN. This prevents half-written matches.
//  Simultaneous events:
//   - CPU write to CTRL of the channel being scanned wins; no match is taken for that channel that cycle.
//   - W1C clear and hardware set of the same pending bit in the same cycle: set wins.
//   - MASK changes take effect on irq the next cycle.
//  timer_value moving backwards (timer soft reset) gets no special handling; compares simply stop matching.
//  Reset mid-operation: all state returns to reset values immediately. Any in-flight ready is dropped.
// STRUCTURE
//  Shared header iob_timer_alarm.vh: register offsets (DEADLINE_LO=0, DEADLINE_HI=1, PERIOD=2, CTRL=3), CTRL bit positions, PENDING/MASK offsets as functions of N_ALARMS.
//  Sub-module iob_timer_alarm_chan: one channel's deadline/period/ctrl storage plus reload adder, instanced N times.
//  Scanner, shared comparator, pending/mask and bus decode stay in the top level.
// TESTING
//  1. One-shot: timer_value=100, ch0 deadline=150, EN=1. At timer_value=150, pending[0]=1 within <=4 cycles and irq=1 (mask=1) the cycle after; CTRL.EN reads 0.
//  2. Periodic: ch1 deadline=1000, PERIOD=200, PERIODIC|EN. Over timer 1000..1700, fires at 1000,1200,1400,1600; DEADLINE reads 1800 after the 4th; PERIOD=0 variant fires once.
//  3. Catch-up and wrap: ch2 deadline=2^64-10, PERIOD=20, timer at 2^64-5. Fires; deadline wraps to 10; no further fire while timer_value < 10.
//  4. Protection: with EN=1, write DEADLINE_LO=0 to ch3 (deadline 5000, timer 100). Readback is still 5000; no fire.
//  5. Collisions: force W1C of pending[0] in the same cycle as a ch0 match -> pending[0] stays 1. A CTRL write on the scan cycle suppresses the match.
//  6. Async rst asserted mid-scan with pending=0xF and irq=1 -> irq, ready, pending, mask and ptr are 0 before the next clk edge.

Source files
------------

// File: rtl/iob_timer_alarm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// iob_timer_alarm_ctrl_pkg
// Shared definitions for the alarm scheduler: per-channel register offsets,
// CTRL bit positions, the PENDING/MASK word addresses (functions of the
// channel count) and a byte-strobe merge helper used by all writable words.
// No ports (package).
// ----------------------------------------------------------------------------
package iob_timer_alarm_ctrl_pkg;

    // Word offset inside a channel's 4-word block (address[1:0]).
    typedef enum logic [1:0] {
        OFF_DEADLINE_LO = 2'd0,
        OFF_DEADLINE_HI = 2'd1,
        OFF_PERIOD      = 2'd2,
        OFF_CTRL        = 2'd3
    } reg_off_e;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PERIODIC_BIT = 1;

    // The global registers sit right after the last channel block.
    function automatic int pending_addr(input int n_alarms);
        return 4 * n_alarms;
    endfunction

    function automatic int mask_addr(input int n_alarms);
        return 4 * n_alarms + 1;
    endfunction

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/iob_timer_alarm_ctrl_if.sv
// ----------------------------------------------------------------------------
// iob_timer_alarm_ctrl_if
// Native CPU slave bus of the alarm scheduler.
//   valid    request strobe (master -> slave)
//   address  word address
//   wdata    write data
//   wstrb    byte strobes, any bit set means write
//   rdata    registered read data (slave -> master)
//   ready    request done, one cycle after valid
// ----------------------------------------------------------------------------
interface iob_timer_alarm_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                valid;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_timer_alarm_chan.sv
// ----------------------------------------------------------------------------
// iob_timer_alarm_chan
// Storage for one alarm channel: 64-bit deadline, 32-bit period, EN and
// PERIODIC flags, plus the reload adder applied when the channel fires.
//   clk, rst          clock, asynchronous active-high reset
//   wr_lo/wr_hi       CPU write to DEADLINE_LO / DEADLINE_HI
//   wr_period         CPU write to PERIOD
//   wr_ctrl           CPU write to CTRL
//   wdata, wstrb      CPU write data and byte strobes
//   hit               channel matched on this cycle's scan slot
//   deadline, period  current register contents
//   en, periodic      CTRL flags
// ----------------------------------------------------------------------------
module iob_timer_alarm_chan
    import iob_timer_alarm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_period,
    input  logic        wr_ctrl,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        hit,
    output logic [63:0] deadline,
    output logic [31:0] period,
    output logic        en,
    output logic        periodic
);

    logic reload;

    // A zero period cannot make progress, so it degrades to one-shot.
    assign reload = hit && periodic && (period != '0);

    // Deadline writes are locked out while enabled so the comparator never
    // sees a half-updated 64-bit value. A hit requires EN=1, so the CPU
    // write path and the reload path can never collide.
    // The top suppresses hit whenever CTRL is written, so the CPU wins there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deadline <= '0;
            period   <= '0;
            en       <= 1'b0;
            periodic <= 1'b0;
        end else begin
            if (wr_lo && !en) begin
                deadline[31:0] <= byte_merge(deadline[31:0], wdata, wstrb);
            end else if (wr_hi && !en) begin
                deadline[63:32] <= byte_merge(deadline[63:32], wdata, wstrb);
            end else if (reload) begin
                // Add to the old deadline, not to the timer, so a channel
                // that fell behind keeps firing until it catches up.
                deadline <= deadline + {32'b0, period};
            end

            if (wr_period) begin
                period <= byte_merge(period, wdata, wstrb);
            end

            if (wr_ctrl) begin
                if (wstrb[0]) begin
                    en       <= wdata[CTRL_EN_BIT];
                    periodic <= wdata[CTRL_PERIODIC_BIT];
                end
            end else if (hit && !reload) begin
                en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iob_timer_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// iob_timer_alarm_ctrl
// Multi-channel alarm scheduler for the 64-bit free-running timer. A
// round-robin scanner time-multiplexes one 64-bit comparator over the
// channels; matches set per-channel pending bits that drive a level irq.
//   clk          system clock
//   rst          asynchronous reset, active-high
//   timer_value  current timer count
//   bus          CPU slave port (valid/address/wdata/wstrb -> rdata/ready)
//   irq          registered |(pending & mask)
// ----------------------------------------------------------------------------
module iob_timer_alarm_ctrl
    import iob_timer_alarm_ctrl_pkg::*;
#(
    parameter int N_ALARMS = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           timer_value,
    iob_timer_alarm_ctrl_if.slave bus,
    output logic                  irq
);

    localparam int PTR_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int CH_W  = ADDR_W - 2;

    logic [PTR_W-1:0]    ptr;
    logic [63:0]         deadline [N_ALARMS];
    logic [31:0]         period   [N_ALARMS];
    logic [N_ALARMS-1:0] en;
    logic [N_ALARMS-1:0] periodic;
    logic [N_ALARMS-1:0] hit;
    logic [N_ALARMS-1:0] wr_ctrl;
    logic [N_ALARMS-1:0] pending;
    logic [N_ALARMS-1:0] mask;
    logic [N_ALARMS-1:0] pend_clr;
    logic [63:0]         scan_deadline;
    logic                scan_ge;
    logic                is_write;
    logic                wr_req;
    logic                pend_sel;
    logic                mask_sel;
    logic [CH_W-1:0]     addr_ch;
    logic [1:0]          addr_off;
    logic [DATA_W-1:0]   rd_word;

    assign is_write = |bus.wstrb;
    assign wr_req   = bus.valid && is_write;
    assign addr_ch  = bus.address[ADDR_W-1:2];
    assign addr_off = bus.address[1:0];
    assign pend_sel = (bus.address == ADDR_W'(pending_addr(N_ALARMS)));
    assign mask_sel = (bus.address == ADDR_W'(mask_addr(N_ALARMS)));

    // Scan pointer walks 0..N-1 every cycle regardless of activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (ptr == PTR_W'(N_ALARMS - 1)) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + 1'b1;
        end
    end

    // The single shared comparator: pick the scanned channel's deadline.
    always_comb begin
        scan_deadline = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (ptr == PTR_W'(i)) begin
                scan_deadline = deadline[i];
            end
        end
    end

    assign scan_ge = (timer_value >= scan_deadline);

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_chan
        logic sel_ch;
        logic wr_lo;
        logic wr_hi;
        logic wr_period;

        assign sel_ch     = wr_req && (addr_ch == CH_W'(i));
        assign wr_lo      = sel_ch && (addr_off == OFF_DEADLINE_LO);
        assign wr_hi      = sel_ch && (addr_off == OFF_DEADLINE_HI);
        assign wr_period  = sel_ch && (addr_off == OFF_PERIOD);
        assign wr_ctrl[i] = sel_ch && (addr_off == OFF_CTRL);

        // A CTRL write on the channel's own slot takes priority over a match.
        assign hit[i] = (ptr == PTR_W'(i)) && en[i] && scan_ge && !wr_ctrl[i];

        iob_timer_alarm_chan u_chan (
            .clk       (clk),
            .rst       (rst),
            .wr_lo     (wr_lo),
            .wr_hi     (wr_hi),
            .wr_period (wr_period),
            .wr_ctrl   (wr_ctrl[i]),
            .wdata     (bus.wdata),
            .wstrb     (bus.wstrb),
            .hit       (hit[i]),
            .deadline  (deadline[i]),
            .period    (period[i]),
            .en        (en[i]),
            .periodic  (periodic[i])
        );
    end

    assign pend_clr = (wr_req && pend_sel && bus.wstrb[0]) ? bus.wdata[N_ALARMS-1:0] : '0;

    // Pending is W1C; a hardware set in the same cycle beats the clear.
    // irq is registered from the pre-edge pending/mask, hence one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~pend_clr) | hit;
            if (wr_req && mask_sel && bus.wstrb[0]) begin
                mask <= bus.wdata[N_ALARMS-1:0];
            end
            irq <= |(pending & mask);
        end
    end

    // Read mux; anything not decoded stays zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (addr_ch == CH_W'(i)) begin
                case (addr_off)
                    OFF_DEADLINE_LO: rd_word = deadline[i][31:0];
                    OFF_DEADLINE_HI: rd_word = deadline[i][63:32];
                    OFF_PERIOD:      rd_word = period[i];
                    OFF_CTRL:        rd_word = DATA_W'({periodic[i], en[i]});
                endcase
            end
        end
        if (pend_sel) begin
            rd_word = DATA_W'(pending);
        end
        if (mask_sel) begin
            rd_word = DATA_W'(mask);
        end
    end

    // Single-cycle response; read data is captured from pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= bus.valid;
            bus.rdata <= (bus.valid && !is_write) ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_iob_timer_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iob_timer_alarm_ctrl
// Self-checking bench for the alarm scheduler. Bus requests push their
// expected read data into a scoreboard; a monitor pops on each ready.
// ----------------------------------------------------------------------------
module tb_iob_timer_alarm_ctrl;

    localparam int N    = 4;
    localparam int AW   = 5;
    localparam int PEND = 16;
    localparam int MASK = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] timer_value;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_exp [$];
    bit          sb_rd  [$];
    string       sb_tag [$];
    logic [31:0] mon_exp;
    bit          mon_rd;
    string       mon_tag;
    int          model_ptr;

    iob_timer_alarm_ctrl_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    iob_timer_alarm_ctrl #(
        .N_ALARMS (N),
        .ADDR_W   (AW),
        .DATA_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .timer_value (timer_value),
        .bus         (bus),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Reference scan position: resets to 0 and advances every cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) model_ptr <= 0;
        else     model_ptr <= (model_ptr == N - 1) ? 0 : model_ptr + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: every ready retires the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            if (sb_exp.size() == 0) begin
                checkOutput("sb_unexpected_ready", 1, 0);
            end else begin
                mon_exp = sb_exp.pop_front();
                mon_rd  = sb_rd.pop_front();
                mon_tag = sb_tag.pop_front();
                if (mon_rd) checkOutput(mon_tag, bus.rdata, mon_exp);
            end
        end
    end

    // Called at a falling edge; drives one request for exactly one cycle.
    task automatic applyStimulus(input bit wr, input int addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [31:0] exp, input string tag);
        bus.valid   = 1'b1;
        bus.address = AW'(addr);
        bus.wdata   = data;
        bus.wstrb   = wr ? strb : 4'h0;
        sb_exp.push_back(exp);
        sb_rd.push_back(!wr);
        sb_tag.push_back(tag);
        @(negedge clk);
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 4'hF, 32'h0, "wr");
    endtask

    task automatic rd(input int addr, input logic [31:0] exp, input string tag);
        applyStimulus(1'b0, addr, 32'h0, 4'h0, exp, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align_ptr0();
        int guard = 0;
        while (model_ptr != 0 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
    endtask

    function automatic int adr(input int ch, input int off);
        return 4 * ch + off;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int t;

        rst         = 1'b1;
        timer_value = 64'd0;
        bus.valid   = 1'b0;
        bus.address = '0;
        bus.wdata   = '0;
        bus.wstrb   = '0;

        #12;
        checkOutput("rst_irq", irq, 0);
        checkOutput("rst_ready", bus.ready, 0);
        checkOutput("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        rd(PEND, 0, "rst_pending");
        rd(MASK, 0, "rst_mask");
        rd(adr(0, 3), 0, "rst_ctrl0");
        rd(adr(2, 0), 0, "rst_dlo2");

        // One-shot on channel 0.
        $display("[TB] one-shot");
        timer_value = 64'd100;
        wr(MASK, 1);
        wr(adr(0, 0), 150);
        wr(adr(0, 1), 0);
        wr(adr(0, 3), 1);
        timer_value = 64'd149;
        idle(8);
        rd(PEND, 0, "t1_no_early");
        checkOutput("t1_irq_low", irq, 0);
        timer_value = 64'd150;
        lat = 0;
        while (irq !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("t1_irq_latency_le5", lat <= 5, 1);
        checkOutput("t1_irq_latency_ge2", lat >= 2, 1);
        rd(PEND, 1, "t1_pending");
        rd(adr(0, 3), 0, "t1_en_cleared");
        rd(adr(0, 0), 150, "t1_deadline_kept");
        wr(PEND, 1);
        rd(PEND, 0, "t1_w1c");
        checkOutput("t1_irq_drop", irq, 0);

        // Periodic on channel 1.
        $display("[TB] periodic");
        wr(MASK, 2);
        timer_value = 64'd990;
        wr(adr(1, 0), 1000);
        wr(adr(1, 1), 0);
        wr(adr(1, 2), 200);
        wr(adr(1, 3), 3);
        for (int k = 0; k < 4; k++) begin
            t = 1000 + 200 * k;
            timer_value = 64'(t - 1);
            idle(6);
            rd(PEND, 0, $sformatf("t2_quiet_%0d", t));
            rd(adr(1, 0), 32'(t), $sformatf("t2_dl_before_%0d", t));
            timer_value = 64'(t);
            idle(6);
            rd(PEND, 2, $sformatf("t2_fire_%0d", t));
            rd(adr(1, 0), 32'(t + 200), $sformatf("t2_dl_after_%0d", t));
            checkOutput($sformatf("t2_irq_%0d", t), irq, 1);
            wr(PEND, 2);
        end
        timer_value = 64'd1700;
        idle(8);
        rd(PEND, 0, "t2_no_fire_1700");
        rd(adr(1, 0), 1800, "t2_dl_1800");
        rd(adr(1, 1), 0, "t2_dh_0");
        rd(adr(1, 3), 3, "t2_ctrl_still_on");
        wr(adr(1, 3), 0);
        wr(adr(1, 2), 0);
        wr(adr(1, 0), 2000);
        wr(adr(1, 3), 3);
        timer_value = 64'd2000;
        idle(6);
        rd(PEND, 2, "t2p0_fire");
        rd(adr(1, 3), 2, "t2p0_en_cleared");
        rd(adr(1, 0), 2000, "t2p0_no_reload");
        wr(PEND, 2);
        timer_value = 64'd2500;
        idle(8);
        rd(PEND, 0, "t2p0_fires_once");

        // Wrap-around reload on channel 2.
        $display("[TB] wrap");
        wr(MASK, 4);
        timer_value = 64'd5;
        wr(adr(2, 0), 32'hFFFF_FFF6);
        wr(adr(2, 1), 32'hFFFF_FFFF);
        wr(adr(2, 2), 20);
        wr(adr(2, 3), 3);
        timer_value = 64'hFFFF_FFFF_FFFF_FFFB;
        idle(4);
        timer_value = 64'd0;
        idle(8);
        rd(PEND, 4, "t3_fire");
        rd(adr(2, 0), 10, "t3_dl_lo_wrapped");
        rd(adr(2, 1), 0, "t3_dl_hi_wrapped");
        wr(PEND, 4);
        timer_value = 64'd9;
        idle(8);
        rd(PEND, 0, "t3_quiet_below_10");
        rd(adr(2, 0), 10, "t3_dl_still_10");
        timer_value = 64'd10;
        idle(6);
        rd(PEND, 4, "t3_fire_at_10");
        rd(adr(2, 0), 30, "t3_dl_30");
        wr(adr(2, 3), 0);
        wr(PEND, 4);

        // Deadline write protection on channel 3.
        $display("[TB] protection");
        wr(MASK, 8);
        timer_value = 64'd100;
        wr(adr(3, 0), 5000);
        wr(adr(3, 1), 0);
        wr(adr(3, 3), 1);
        wr(adr(3, 0), 0);
        rd(adr(3, 0), 5000, "t4_locked");
        idle(8);
        rd(PEND, 0, "t4_no_fire");
        checkOutput("t4_irq_low", irq, 0);
        wr(adr(3, 3), 0);
        applyStimulus(1'b1, adr(3, 0), 32'h0000_00AB, 4'b0001, 32'h0, "wr_strb");
        rd(adr(3, 0), 32'h0000_13AB, "t4_byte_strobe");
        wr(18, 32'hFFFF_FFFF);
        rd(18, 0, "unmapped_18");
        rd(31, 0, "unmapped_31");

        // Collisions on channel 0.
        $display("[TB] collisions");
        wr(MASK, 1);
        wr(adr(0, 0), 3000);
        wr(adr(0, 1), 0);
        timer_value = 64'd2999;
        wr(adr(0, 3), 1);
        idle(6);
        rd(PEND, 0, "t5_armed");
        align_ptr0();
        timer_value = 64'd3000;
        wr(PEND, 1);
        rd(PEND, 1, "t5_set_beats_clear");
        rd(adr(0, 3), 0, "t5_oneshot_done");
        wr(PEND, 1);
        wr(adr(0, 0), 4000);
        timer_value = 64'd3999;
        wr(adr(0, 3), 1);
        idle(6);
        rd(PEND, 0, "t5b_armed");
        align_ptr0();
        timer_value = 64'd4000;
        wr(adr(0, 3), 1);
        rd(PEND, 0, "t5b_ctrl_write_suppresses");
        idle(6);
        rd(PEND, 1, "t5b_fires_next_slot");
        rd(adr(0, 3), 0, "t5b_en_cleared");
        wr(PEND, 1);

        // Asynchronous reset with everything pending.
        $display("[TB] async reset");
        timer_value = 64'd50;
        for (int ch = 0; ch < N; ch++) begin
            wr(adr(ch, 0), 0);
            wr(adr(ch, 1), 0);
            wr(adr(ch, 3), 1);
        end
        wr(MASK, 32'hF);
        idle(8);
        rd(PEND, 32'hF, "t6_all_pending");
        checkOutput("t6_irq_high", irq, 1);
        bus.valid   = 1'b1;
        bus.address = AW'(PEND);
        bus.wstrb   = 4'h0;
        @(posedge clk);
        #2;
        checkOutput("t6_ready_inflight", bus.ready, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_irq_async", irq, 0);
        checkOutput("t6_ready_async", bus.ready, 0);
        checkOutput("t6_rdata_async", bus.rdata, 0);
        checkOutput("t6_pending_async", dut.pending, 0);
        checkOutput("t6_mask_async", dut.mask, 0);
        checkOutput("t6_ptr_async", dut.ptr, 0);
        bus.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(PEND, 0, "t6_pending_after");
        rd(MASK, 0, "t6_mask_after");
        rd(adr(0, 3), 0, "t6_ctrl_after");
        rd(adr(1, 0), 0, "t6_dlo_after");
        idle(2);

        checkOutput("sb_drained", sb_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
